// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O controller: synchronised keys/switches with status, LEDs and 7-segment digits.
// Optional interrupt output enabled by defining IO_IRQ_EN.
module mmio_io_ctrl #(
    parameter int              DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX       = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR      = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG      = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY       = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW        = 32'hF0000014,
    parameter int              NUM_KEYS        = 4,
    parameter int              NUM_SW          = 10,
    parameter int              NUM_LEDR        = 10,
    parameter int              NUM_LEDG        = 8,
    parameter int              NUM_HEX         = 4,
    parameter int              DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  FPGA_RESET_N,
    input  logic [DBITS-1:0]      addr,
    input  logic                  we,
    input  logic                  re,
    input  logic [DBITS-1:0]      wrData,
    output logic [DBITS-1:0]      rdData,
    input  logic [NUM_KEYS-1:0]   KEY,
    input  logic [NUM_SW-1:0]     SW,
    output logic [NUM_LEDR-1:0]   LEDR,
    output logic [NUM_LEDG-1:0]   LEDG,
    output logic [7*NUM_HEX-1:0]  HEX,
    output logic                  irq
);
    localparam int HW = 4 * NUM_HEX;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBITS-1:0] ADDR_KSTAT = DBITS'(ADDR_KEY + 32'h100);
    localparam logic [DBITS-1:0] ADDR_SSTAT = DBITS'(ADDR_SW + 32'h100);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

    logic [NUM_KEYS-1:0]  key_meta_q, key_sync_q, key_prev_q;
    logic [NUM_SW-1:0]    sw_meta_q, sw_sync_q, sw_stable_q, sw_stable_d;
    logic [CW-1:0]        deb_cnt_q, deb_cnt_d;
    logic                 sw_accept_s, key_edge_s;
    logic [HW-1:0]        hex_q, hex_d;
    logic [7*NUM_HEX-1:0] seg_q, seg_d;
    logic [NUM_LEDR-1:0]  ledr_q, ledr_d;
    logic [NUM_LEDG-1:0]  ledg_q, ledg_d;
    logic                 kst_rdy_q, kst_rdy_d, kst_ovr_q, kst_ovr_d, kst_ie_q, kst_ie_d;
    logic                 sst_rdy_q, sst_rdy_d, sst_ovr_q, sst_ovr_d, sst_ie_q, sst_ie_d;
    logic                 irq_q, irq_d;
    logic [DBITS-1:0]     rd_q, rd_d;
    logic                 wr_hex_s, wr_ledr_s, wr_ledg_s, wr_kst_s, wr_sst_s;

    // Switch debounce: one shared counter; only a return to the stable value restarts it
    always_comb begin
        deb_cnt_d   = deb_cnt_q;
        sw_stable_d = sw_stable_q;
        sw_accept_s = 1'b0;
        if (sw_sync_q == sw_stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            sw_stable_d = sw_sync_q;
            deb_cnt_d   = '0;
            sw_accept_s = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + CW'(1);
        end
    end

    // Write address decode; data-register and unmapped writes fall through
    always_comb begin
        wr_hex_s  = 1'b0;
        wr_ledr_s = 1'b0;
        wr_ledg_s = 1'b0;
        wr_kst_s  = 1'b0;
        wr_sst_s  = 1'b0;
        if (we) begin
            case (addr)
                ADDR_HEX:   wr_hex_s  = 1'b1;
                ADDR_LEDR:  wr_ledr_s = 1'b1;
                ADDR_LEDG:  wr_ledg_s = 1'b1;
                ADDR_KSTAT: wr_kst_s  = 1'b1;
                ADDR_SSTAT: wr_sst_s  = 1'b1;
                default:    wr_hex_s  = 1'b0;
            endcase
        end else begin
            wr_hex_s = 1'b0;
        end
    end

    // Register next-state: set events override a same-cycle write-1-to-clear
    always_comb begin
        key_edge_s = |(key_sync_q & ~key_prev_q);
        hex_d  = wr_hex_s  ? wrData[HW-1:0]       : hex_q;
        ledr_d = wr_ledr_s ? wrData[NUM_LEDR-1:0] : ledr_q;
        ledg_d = wr_ledg_s ? wrData[NUM_LEDG-1:0] : ledg_q;
        kst_rdy_d = (kst_rdy_q & ~(wr_kst_s & wrData[0])) | key_edge_s;
        kst_ovr_d = (kst_ovr_q & ~(wr_kst_s & wrData[1])) | (key_edge_s & kst_rdy_q);
        sst_rdy_d = (sst_rdy_q & ~(wr_sst_s & wrData[0])) | sw_accept_s;
        sst_ovr_d = (sst_ovr_q & ~(wr_sst_s & wrData[1])) | (sw_accept_s & sst_rdy_q);
`ifdef IO_IRQ_EN
        kst_ie_d = wr_kst_s ? wrData[8] : kst_ie_q;
        sst_ie_d = wr_sst_s ? wrData[8] : sst_ie_q;
        irq_d    = (kst_rdy_q & kst_ie_q) | (sst_rdy_q & sst_ie_q);
`else
        kst_ie_d = 1'b0;
        sst_ie_d = 1'b0;
        irq_d    = 1'b0;
`endif
        for (int i = 0; i < NUM_HEX; i++) begin
            seg_d[7*i +: 7] = hex7(hex_q[4*i +: 4]);
        end
    end

    // Read mux sees pre-write register values; holds when no read is issued
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = '0;
            case (addr)
                ADDR_HEX:   rd_d[HW-1:0]       = hex_q;
                ADDR_LEDR:  rd_d[NUM_LEDR-1:0] = ledr_q;
                ADDR_LEDG:  rd_d[NUM_LEDG-1:0] = ledg_q;
                ADDR_KEY:   rd_d[NUM_KEYS-1:0] = key_sync_q;
                ADDR_SW:    rd_d[NUM_SW-1:0]   = sw_stable_q;
                ADDR_KSTAT: begin
                    rd_d[0] = kst_rdy_q;
                    rd_d[1] = kst_ovr_q;
                    rd_d[8] = kst_ie_q;
                end
                ADDR_SSTAT: begin
                    rd_d[0] = sst_rdy_q;
                    rd_d[1] = sst_ovr_q;
                    rd_d[8] = sst_ie_q;
                end
                default:    rd_d = '0;
            endcase
        end else begin
            rd_d = rd_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!FPGA_RESET_N) begin
            key_meta_q  <= '0;
            key_sync_q  <= '0;
            key_prev_q  <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            sw_stable_q <= '0;
            deb_cnt_q   <= '0;
            hex_q       <= '0;
            seg_q       <= {NUM_HEX{7'b1000000}};
            ledr_q      <= '0;
            ledg_q      <= '0;
            kst_rdy_q   <= 1'b0;
            kst_ovr_q   <= 1'b0;
            kst_ie_q    <= 1'b0;
            sst_rdy_q   <= 1'b0;
            sst_ovr_q   <= 1'b0;
            sst_ie_q    <= 1'b0;
            irq_q       <= 1'b0;
            rd_q        <= '0;
        end else begin
            key_meta_q  <= ~KEY;
            key_sync_q  <= key_meta_q;
            key_prev_q  <= key_sync_q;
            sw_meta_q   <= SW;
            sw_sync_q   <= sw_meta_q;
            sw_stable_q <= sw_stable_d;
            deb_cnt_q   <= deb_cnt_d;
            hex_q       <= hex_d;
            seg_q       <= seg_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
            kst_rdy_q   <= kst_rdy_d;
            kst_ovr_q   <= kst_ovr_d;
            kst_ie_q    <= kst_ie_d;
            sst_rdy_q   <= sst_rdy_d;
            sst_ovr_q   <= sst_ovr_d;
            sst_ie_q    <= sst_ie_d;
            irq_q       <= irq_d;
            rd_q        <= rd_d;
        end
    end

    assign rdData = rd_q;
    assign LEDR   = ledr_q;
    assign LEDG   = ledg_q;
    assign HEX    = seg_q;
    assign irq    = irq_q;
endmodule
